// File: rtl/ipbus_fifo_slave.sv
// rtl/ipbus_fifo_slave.sv - IPbus slave pushing written words into a FIFO drained over a valid/ready stream
//
// Purpose:
//   The IPbus master writes command words to the DATA address. They are queued in
//   a register-array FIFO and presented to downstream fabric as a first-word-fall-through
//   stream. A STATUS/CTRL address reports occupancy and a sticky overflow flag, and
//   accepts flush / overflow-clear commands.
//
// Ports:
//   clk        in   IPbus clock, all state on the rising edge
//   reset      in   asynchronous, active-high reset
//   ipbus_in   in   [65:34] addr, [33:2] wdata, [1] strobe, [0] write
//   ipbus_out  out  [33:2] rdata, [1] ack, [0] err
//   m_data     out  head-of-FIFO word, 0 while the FIFO is empty
//   m_valid    out  FIFO not empty
//   m_ready    in   downstream takes m_data when m_valid && m_ready
//
// Address map (addr[0] only, upper bits decoded upstream):
//   0  DATA         write: push (err + sticky overflow when full); read: see below
//   1  STATUS/CTRL  read: [15:0] count, [16] empty, [17] full, [18] overflow
//                   write: bit0 flush, bit1 clear overflow
//
// Build option:
//   IPBUS_FIFO_PEEK_EN  when defined, a DATA read returns the head word with ack
//                       (no pop), or 0 with err if the FIFO is empty. When not
//                       defined, every DATA read answers 0 with err.

module ipbus_fifo_slave #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [65:0]           ipbus_in,
    output logic [33:0]           ipbus_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    // ------------------------------------------------------------------
    // Request field extraction
    // ------------------------------------------------------------------
    logic                  req_strobe;
    logic                  req_write;
    logic                  req_sel_ctrl;
    logic [DATA_WIDTH-1:0] req_wdata;

    assign req_strobe   = ipbus_in[1];
    assign req_write    = ipbus_in[0];
    assign req_sel_ctrl = ipbus_in[34];
    assign req_wdata    = ipbus_in[2 +: DATA_WIDTH];

    // Upper address bits are decoded by the fabric, not here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ipbus_in[65:35];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic                  ack_q,    ack_d;
    logic                  err_q,    err_d;
    logic [31:0]           rdata_q,  rdata_d;
    // Set once the current strobe has been answered; cleared when strobe drops,
    // so a strobe held high for many cycles yields exactly one response.
    logic                  held_q,   held_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        do_push;
    logic        do_pop;
    logic        do_flush;
    logic        do_ovf_clr;
    logic [15:0] count_ext;
    logic [31:0] status_word;
    logic [DATA_WIDTH-1:0] head_word;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never makes room for a push into a full FIFO.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = count_q[DEPTH_LOG2];
    assign head_word  = mem_q[rd_ptr_q];

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : head_word;

    assign accept = req_strobe && !held_q && !ack_q && !err_q;
    assign do_pop = !fifo_empty && m_ready;

    always_comb begin
        count_ext                 = '0;
        count_ext[DEPTH_LOG2:0]   = count_q;
        status_word               = {13'd0, ovf_q, fifo_full, fifo_empty, count_ext};
    end

    always_comb begin
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        do_push    = 1'b0;
        do_flush   = 1'b0;
        do_ovf_clr = 1'b0;
        ovf_d      = ovf_q;

        if (accept) begin
            if (!req_sel_ctrl) begin
                if (req_write) begin
                    if (fifo_full) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        do_push = 1'b1;
                    end
                end else begin
`ifdef IPBUS_FIFO_PEEK_EN
                    if (fifo_empty) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        rdata_d = head_word;
                    end
`else
                    err_d = 1'b1;
`endif
                end
            end else begin
                ack_d = 1'b1;
                if (req_write) begin
                    do_flush   = req_wdata[0];
                    do_ovf_clr = req_wdata[1];
                end else begin
                    // Reflects state before this edge's push/pop.
                    rdata_d = status_word;
                end
            end
        end

        if (do_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        held_d = req_strobe && (held_q || accept);
    end

    // Pointer and count update; flush overrides any concurrent pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            held_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            held_q   <= held_d;
        end
    end

    // Storage is not reset; m_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= req_wdata;
        end
    end

    assign ipbus_out = {rdata_q, ack_q, err_q};

endmodule

// File: tb/tb_ipbus_fifo_slave.sv
// tb/tb_ipbus_fifo_slave.sv - self-checking bench for ipbus_fifo_slave with a queue-based reference model
`timescale 1ns/1ps

module tb_ipbus_fifo_slave;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        reset;
    logic [65:0] ipbus_in;
    logic [33:0] ipbus_out;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          ovf_m;
    bit          held_m;
    bit          resp_m;

    ipbus_fifo_slave #(.DEPTH_LOG2(DL), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ipbus_in  (ipbus_in),
        .ipbus_out (ipbus_out),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        ovf_m  = 1'b0;
        held_m = 1'b0;
        resp_m = 1'b0;
    endtask

    // One clock cycle: drive request/m_ready, check stream outputs before the
    // edge and the IPbus response after it, then advance the model.
    task automatic step(input bit stb, input bit wr, input bit a0, input logic [31:0] wd,
                        input bit rdy, input string tag,
                        output bit got_ack, output bit got_err, output logic [31:0] got_rd,
                        output logic [31:0] seen_data, output bit seen_valid);
        logic [31:0] r;
        logic [31:0] exp_rd;
        logic [31:0] exp_md;
        bit acc, exp_ack, exp_err, push, pop, flush, clr, full, empty;
        @(negedge clk);
        r = $urandom();
        ipbus_in = {r[30:0], a0, wd, stb, wr};
        m_ready  = rdy;
        #1;
        empty  = (mq.size() == 0);
        full   = (mq.size() == DEPTH);
        exp_md = empty ? 32'h0 : mq[0];
        seen_data  = m_data;
        seen_valid = m_valid;
        checks++;
        if (m_valid !== !empty) begin
            errors++;
            $display("FAIL %s m_valid: got %b want %b", tag, m_valid, !empty);
        end
        checks++;
        if (m_data !== exp_md) begin
            errors++;
            $display("FAIL %s m_data: got %h want %h", tag, m_data, exp_md);
        end

        acc = stb && !held_m && !resp_m;
        exp_ack = 0; exp_err = 0; exp_rd = 32'h0;
        push = 0; flush = 0; clr = 0;
        pop = rdy && !empty;
        if (acc) begin
            if (!a0) begin
                if (wr) begin
                    if (full) exp_err = 1;
                    else begin exp_ack = 1; push = 1; end
                end else begin
`ifdef IPBUS_FIFO_PEEK_EN
                    if (empty) exp_err = 1;
                    else begin exp_ack = 1; exp_rd = mq[0]; end
`else
                    exp_err = 1;
`endif
                end
            end else begin
                exp_ack = 1;
                if (wr) begin
                    flush = wd[0];
                    clr   = wd[1];
                end else begin
                    exp_rd = {13'h0, ovf_m, full, empty, 16'(mq.size())};
                end
            end
        end

        @(posedge clk);
        #1;
        got_rd  = ipbus_out[33:2];
        got_ack = ipbus_out[1];
        got_err = ipbus_out[0];
        checks++;
        if (ipbus_out !== {exp_rd, exp_ack, exp_err}) begin
            errors++;
            $display("FAIL %s ipbus_out: got rdata=%h ack=%b err=%b want rdata=%h ack=%b err=%b",
                     tag, ipbus_out[33:2], ipbus_out[1], ipbus_out[0], exp_rd, exp_ack, exp_err);
        end

        if (flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(wd);
        end
        if (acc && !a0 && wr && full) ovf_m = 1'b1;
        if (clr) ovf_m = 1'b0;
        held_m = stb && (held_m || acc);
        resp_m = acc;
    endtask

    // Full transaction: strobe for one cycle, then an idle cycle.
    task automatic xact(input bit wr, input bit a0, input logic [31:0] wd, input bit rdy,
                        input string tag, output bit ack, output bit err, output logic [31:0] rd);
        bit a2, e2, v;
        logic [31:0] r2, d;
        step(1'b1, wr, a0, wd, rdy, tag, ack, err, rd, d, v);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, {tag, "_idle"}, a2, e2, r2, d, v);
    endtask

    task automatic expect_status(input logic [31:0] want, input string tag);
        bit a, e;
        logic [31:0] rd;
        xact(1'b0, 1'b1, 32'h0, 1'b0, tag, a, e, rd);
        checks++;
        if (rd !== want || a !== 1'b1) begin
            errors++;
            $display("FAIL %s status: got %h ack=%b want %h ack=1", tag, rd, a, want);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ipbus_in = '0;
        m_ready  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ipbus_out !== 34'h0 || m_valid !== 1'b0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ipbus_out=%h m_valid=%b m_data=%h want 0/0/0",
                     ipbus_out, m_valid, m_data);
        end
        @(negedge clk);
        reset = 1'b0;
        expect_status(32'h0001_0000, "reset_status");
    endtask

    task automatic test_fill_overflow();
        logic [31:0] words[4] = '{32'h12345678, 32'h456789AB, 32'h789ABCDE, 32'hBCDEF012};
        bit a, e;
        logic [31:0] rd;
        int acks = 0;
        foreach (words[i]) begin
            xact(1'b1, 1'b0, words[i], 1'b0, "fill_push", a, e, rd);
            if (a) acks++;
        end
        checks++;
        if (acks != 4) begin
            errors++;
            $display("FAIL fill_acks: got %0d want 4", acks);
        end
        expect_status(32'h0002_0004, "fill_status");
        xact(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "overflow_push", a, e, rd);
        checks++;
        if (e !== 1'b1 || a !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err: got ack=%b err=%b want ack=0 err=1", a, e);
        end
        expect_status(32'h0006_0004, "overflow_status");
    endtask

    task automatic test_drain();
        logic [31:0] want[4] = '{32'h12345678, 32'h456789AB, 32'h789ABCDE, 32'hBCDEF012};
        bit a, e, v;
        logic [31:0] rd, d;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "drain", a, e, rd, d, v);
            checks++;
            if (d !== want[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL drain_word%0d: got %h valid=%b want %h valid=1", i, d, v, want[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "drain_end", a, e, rd, d, v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got m_valid=%b want 0", v);
        end
        expect_status(32'h0005_0000, "drain_status");
        xact(1'b1, 1'b1, 32'h2, 1'b0, "ovf_clear", a, e, rd);
        expect_status(32'h0001_0000, "ovf_clear_status");
    endtask

    task automatic test_full_push_pop();
        bit a, e, v;
        logic [31:0] rd, d;
        for (int i = 0; i < 4; i++) xact(1'b1, 1'b0, $urandom(), 1'b0, "fpp_fill", a, e, rd);
        step(1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1, "fpp_full_push_pop", a, e, rd, d, v);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop_err: got err=%b want 1", e);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "fpp_idle", a, e, rd, d, v);
        expect_status(32'h0004_0003, "fpp_count3");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "fpp_pop", a, e, rd, d, v);
        step(1'b1, 1'b1, 1'b0, 32'hA5A5_0002, 1'b1, "fpp_push_pop", a, e, rd, d, v);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "fpp_idle2", a, e, rd, d, v);
        expect_status(32'h0004_0002, "fpp_count2");
        xact(1'b1, 1'b1, 32'h2, 1'b0, "fpp_clr", a, e, rd);
    endtask

    task automatic test_strobe_held();
        bit a, e, v;
        logic [31:0] rd, d;
        int acks = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, "held", a, e, rd, d, v);
            if (a) acks++;
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "held_release", a, e, rd, d, v);
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL held_acks: got %0d want 1", acks);
        end
        expect_status(32'h0000_0003, "held_count");
        step(1'b1, 1'b1, 1'b1, 32'h1, 1'b1, "flush_pop", a, e, rd, d, v);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "flush_after", a, e, rd, d, v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got m_valid=%b want 0", v);
        end
        expect_status(32'h0001_0000, "flush_status");
    endtask

    task automatic test_peek();
        bit a, e;
        logic [31:0] rd;
        xact(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, "peek_push", a, e, rd);
        xact(1'b0, 1'b0, 32'h0, 1'b0, "peek_read", a, e, rd);
        checks++;
`ifdef IPBUS_FIFO_PEEK_EN
        if (a !== 1'b1 || e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL peek_read: got ack=%b err=%b rdata=%h want ack=1 err=0 rdata=cafef00d", a, e, rd);
        end
`else
        if (a !== 1'b0 || e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL data_read: got ack=%b err=%b rdata=%h want ack=0 err=1 rdata=0", a, e, rd);
        end
`endif
        expect_status(32'h0000_0001, "peek_count");
        xact(1'b1, 1'b1, 32'h1, 1'b0, "peek_flush", a, e, rd);
    endtask

    task automatic test_random();
        bit a, e, v, stb, wr, a0, rdy;
        logic [31:0] rd, d, r, wd;
        for (int i = 0; i < 600; i++) begin
            r   = $urandom();
            stb = r[0] | r[1];
            wr  = r[2] | r[3];
            a0  = (r[6:4] == 3'd0);
            wd  = $urandom();
            if (a0 && wr) wd[0] = (r[10:8] == 3'd0);
            rdy = (i < 300) ? (r[17:16] == 2'd0) : r[16];
            step(stb, wr, a0, wd, rdy, "random", a, e, rd, d, v);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "random_end", a, e, rd, d, v);
    endtask

    task automatic test_reset_mid();
        bit a, e, v;
        logic [31:0] rd, d;
        xact(1'b1, 1'b0, 32'h1111_2222, 1'b0, "rm_push", a, e, rd);
        step(1'b1, 1'b1, 1'b0, 32'h3333_4444, 1'b0, "rm_push2", a, e, rd, d, v);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ipbus_out !== 34'h0 || m_valid !== 1'b0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got ipbus_out=%h m_valid=%b m_data=%h want 0/0/0",
                     ipbus_out, m_valid, m_data);
        end
        ipbus_in = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        expect_status(32'h0001_0000, "reset_mid_status");
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain();
        test_full_push_pop();
        test_strobe_held();
        test_peek();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
